// File: rtl/lum_pkg.sv
// lum_pkg: shared widths, saturation constants and FSM states for the luminance encoder
package lum_pkg;
    localparam int LUM_E_W = 4;
    localparam int LUM_M_W = 8;
    localparam logic [LUM_E_W-1:0] LUM_E_SAT = 4'hF;
    localparam int LUM_E_MAX = 14;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} lum_enc_state_t;
endpackage

// File: rtl/lum_enc.sv
// lum_enc: serial float-style encoder of linear luminance into an exponent and an 8-bit mantissa
module lum_enc
    import lum_pkg::*;
#(
    parameter int LIN_W = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LIN_W-1:0]   lum_lin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LUM_E_W-1:0] lum_e,
    output logic [LUM_M_W-1:0] lum_m
);
    lum_enc_state_t     state_q, state_d;
    logic [LIN_W-1:0]   work_q, work_d;
    logic [4:0]         exp_q, exp_d;
    logic               rbit_q, rbit_d;
    logic [LUM_E_W-1:0] lum_e_q, lum_e_d;
    logic [LUM_M_W-1:0] lum_m_q, lum_m_d;
    logic [8:0]         sum;
    logic [4:0]         exp_r;
    logic [7:0]         m_r;
    logic               sat;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == HOLD;
    assign lum_e     = lum_e_q;
    assign lum_m     = lum_m_q;

    // normalise one bit per cycle, then round half up on the last shifted-out bit and saturate
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        exp_d   = exp_q;
        rbit_d  = rbit_q;
        lum_e_d = lum_e_q;
        lum_m_d = lum_m_q;
        sum     = {1'b0, work_q[7:0]} + {8'b0, rbit_q};
        exp_r   = exp_q + {4'b0, sum[8]};
        m_r     = sum[8] ? 8'h80 : sum[7:0];
        sat     = exp_r > 5'(LUM_E_MAX);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = lum_lin;
                    exp_d   = 5'd0;
                    rbit_d  = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (|work_q[LIN_W-1:8]) begin
                    work_d = work_q >> 1;
                    rbit_d = work_q[0];
                    exp_d  = exp_q + 5'd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                exp_d   = exp_r;
                lum_e_d = sat ? LUM_E_SAT : exp_r[3:0];
                lum_m_d = sat ? 8'hFF : m_r;
                state_d = HOLD;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any encode in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            exp_q   <= '0;
            rbit_q  <= 1'b0;
            lum_e_q <= '0;
            lum_m_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            exp_q   <= exp_d;
            rbit_q  <= rbit_d;
            lum_e_q <= lum_e_d;
            lum_m_q <= lum_m_d;
        end
    end
endmodule
